cast_width_pipe: RTL
====================

CAST_WIDTH_PIPE -- requirements
Module: cast_width_pipe

Interface
REQ-001 The module SHALL have parameter IN_W, default 32, meaning input data width (2..64).
REQ-002 The module SHALL have parameter OUT_W, default cast_pkg::OUT_W_DEF (4), meaning output data width (1..IN_W).
REQ-003 The module SHALL have parameter DEPTH, default 2, meaning buffer entries (power of two, 2..16).
REQ-004 The module SHALL have parameter MODE, default cast_pkg::CAST_TRUNC, meaning cast mode: CAST_TRUNC, CAST_SAT_U or CAST_SAT_S.
REQ-005 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-006 The module SHALL have port in_valid input 1, meaning input word offered.
REQ-007 The module SHALL have port in_ready output 1, meaning the buffer can accept a word.
REQ-008 The module SHALL have port in_data input IN_W, meaning the value to cast.
REQ-009 The module SHALL have port out_valid output 1, meaning the head entry is available.
REQ-010 The module SHALL have port out_ready input 1, meaning the consumer accepts the head entry.
REQ-011 The module SHALL have port out_data output OUT_W, meaning the cast value at the head.
REQ-012 The module SHALL have port out_clip output 1, meaning the head value was altered by the cast.

Function
REQ-013 A push SHALL occur on a rising clk when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-014 in_ready SHALL equal (count != DEPTH), with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0); a pushed word SHALL appear on out_data on the cycle after the push (latency 1).
REQ-016 CAST_TRUNC: out_data SHALL be in_data[OUT_W-1:0]; out_clip SHALL be 1 iff any of bits in_data[IN_W-1:OUT_W] is nonzero.
REQ-017 CAST_SAT_U: values above 2^OUT_W-1 SHALL yield all-ones with out_clip=1; otherwise the low bits SHALL be output with out_clip=0.
REQ-018 CAST_SAT_S: the input SHALL be treated as two's complement and clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_clip SHALL be 1 iff clamped.
REQ-019 When IN_W == OUT_W, out_data SHALL equal in_data and out_clip SHALL be 0 in all modes.
REQ-020 The cast SHALL be computed before storage; each entry SHALL hold OUT_W+1 bits.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and preserve order; this SHALL be legal at full only if in_ready was 1, which does not hold at full.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-023 When out_valid=0, out_data and out_clip SHALL be driven to 0.
REQ-024 A pop while empty and a push while full SHALL be ignored, with no state change.

Reset
REQ-025 While rst=1, count, both pointers, out_valid, out_data and out_clip SHALL be 0, and in_ready SHALL be 0.
REQ-026 A reset mid-transfer SHALL discard all buffered entries; in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-027 Storage array contents SHALL NOT require reset.

Configuration
REQ-028 With CAST_WIDTH_PIPE_STATS_EN defined, the module SHALL add port clip_count output 16, counting pushes whose cast clipped, saturating at 16'hFFFF and cleared by rst.
REQ-029 Without CAST_WIDTH_PIPE_STATS_EN, the clip_count port and its counter SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-030 Package cast_pkg SHALL hold OUT_W_DEF (4), enum cast_mode_e (CAST_TRUNC, CAST_SAT_U, CAST_SAT_S) and function-free width constants only.
REQ-031 The combinational cast SHALL be a sub-module cast_unit (parameters IN_W, OUT_W, MODE; ports in_data, out_data, clip); the buffer SHALL be inline.

Verification
REQ-032 With TRUNC, IN_W=32, OUT_W=4: push 32'd1 -> next cycle out_data=4'h1, out_clip=0.
REQ-033 With TRUNC: push 32'h13 -> out_data=4'h3, out_clip=1; with SAT_U: push 32'h13 -> out_data=4'hF, out_clip=1.
REQ-034 With SAT_S: push 32'hFFFFFFF0 (-16) -> out_data=4'h8, out_clip=1; push 32'hFFFFFFFE -> out_data=4'hE, out_clip=0.
REQ-035 With DEPTH=2 and out_ready=0: push 5, 6 -> in_ready=0; a third push SHALL be ignored; then out_ready=1 -> pops 5 then 6 in consecutive cycles.
REQ-036 Continuous in_valid=1, out_ready=1 over 20 words -> one word per cycle, count stable at 1, order preserved across pointer wrap.
REQ-037 Assert rst with 2 entries held -> out_valid=0 immediately; after release, clip_count=0 (STATS_EN) and the next push emerges alone.

Source files
------------

// File: rtl/cast_width_pipe_pkg.sv
// cast_pkg: shared cast modes and default widths for cast_width_pipe
package cast_pkg;
  localparam int IN_W_DEF = 32;
  localparam int OUT_W_DEF = 4;
  localparam int DEPTH_DEF = 2;
  localparam int STATS_W = 16;
  typedef enum logic [1:0] {
    CAST_TRUNC,
    CAST_SAT_U,
    CAST_SAT_S
  } cast_mode_e;
endpackage

// File: rtl/cast_width_pipe_cast_unit.sv
// cast_unit: combinational narrowing cast (truncate, unsigned or signed saturate) with clip flag
module cast_unit
  import cast_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter cast_mode_e MODE = CAST_TRUNC
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             clip
);
  if (IN_W == OUT_W) begin : g_pass
    assign out_data = in_data;
    assign clip = 1'b0;
  end else begin : g_cast
    localparam logic [OUT_W-1:0] S_MIN = OUT_W'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] S_MAX = ~S_MIN;
    logic [IN_W-1:OUT_W] upper;
    logic [IN_W-1:OUT_W-1] sign_run;
    logic hi_set, s_fits;
    assign upper = in_data[IN_W-1:OUT_W];
    assign sign_run = in_data[IN_W-1:OUT_W-1];
    assign hi_set = |upper;
    assign s_fits = (&sign_run) | ~(|sign_run);
    // Signed values fit when every bit above the output sign bit copies it
    always_comb begin
      out_data = in_data[OUT_W-1:0];
      clip = hi_set;
      if (MODE == CAST_SAT_U) out_data = hi_set ? '1 : in_data[OUT_W-1:0];
      if (MODE == CAST_SAT_S) begin
        clip = ~s_fits;
        out_data = s_fits ? in_data[OUT_W-1:0] : (in_data[IN_W-1] ? S_MIN : S_MAX);
      end
    end
  end
endmodule

// File: rtl/cast_width_pipe.sv
// cast_width_pipe: casts input words and buffers them in a small FIFO; optional CAST_WIDTH_PIPE_STATS_EN adds clip_count
module cast_width_pipe
  import cast_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter cast_mode_e MODE = CAST_TRUNC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_clip
`ifdef CAST_WIDTH_PIPE_STATS_EN
  ,output logic [STATS_W-1:0] clip_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic rdy_en, push, pop, cast_clip;
  logic [OUT_W-1:0] cast_data;
  logic [OUT_W:0] mem [DEPTH];
  cast_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .MODE(MODE)) u_cast (
    .in_data (in_data),
    .out_data(cast_data),
    .clip    (cast_clip)
  );
  assign in_ready = rdy_en && (count != (AW+1)'(DEPTH));
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {out_clip, out_data} = out_valid ? mem[rd_ptr] : '0;
  // Pointer and occupancy tracking; rdy_en holds in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Storage holds the already-cast value plus its clip flag; no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cast_clip, cast_data};
  end
`ifdef CAST_WIDTH_PIPE_STATS_EN
  // Saturating count of accepted words whose cast clipped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clip_count <= '0;
    else if (push && cast_clip && clip_count != '1) clip_count <= clip_count + 1'b1;
  end
`endif
endmodule
